// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet controller and datapath: FSM state
// encoding, default sizing and the lateral-inhibition weight.
package maxnet_pkg;

  localparam int MAXNET_N        = 4;
  localparam int MAXNET_MAX_ITER = 64;
  localparam int MAXNET_ITER_W   = 7;
  localparam int MAXNET_IDX_W    = 2;

  // Inhibition weight eps in Q0.8 (about 0.2), kept below 1/N so the
  // largest neuron always survives an update.
  localparam int                 MAXNET_EPS_W = 8;
  localparam logic [7:0]         MAXNET_EPS   = 8'd51;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/maxnet_onehot_check.sv
// Classifies the datapath nonzero flags: exactly one set, none set, and the
// index of the lowest set flag.
module maxnet_onehot_check
  import maxnet_pkg::*;
#(
  parameter int N     = MAXNET_N,
  parameter int IDX_W = MAXNET_IDX_W
) (
  input  logic [N-1:0]     nz_i,
  output logic             is_single_o,
  output logic             is_zero_o,
  output logic [IDX_W-1:0] lowest_idx_o
);

  logic [N-1:0] nz_minus_one_s;

  assign nz_minus_one_s = nz_i - N'(1);
  assign is_zero_o      = (nz_i == {N{1'b0}});
  // Clearing the lowest set bit leaves zero only for a power of two.
  assign is_single_o    = !is_zero_o && ((nz_i & nz_minus_one_s) == {N{1'b0}});

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    lowest_idx_o = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      lowest_idx_o = nz_i[i] ? IDX_W'(i) : lowest_idx_o;
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the Maxnet datapath: load, then compute/update rounds until a
// single neuron survives, everything is inhibited, or the round limit hits.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int N        = MAXNET_N,
  parameter int MAX_ITER = MAXNET_MAX_ITER,
  parameter int ITER_W   = MAXNET_ITER_W,
  parameter int IDX_W    = MAXNET_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      nz,
  output logic              init_ld,
  output logic              comp_en,
  output logic              upd_en,
  output logic [IDX_W-1:0]  sel_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_e              state_q;
  logic                start_q;
  logic                init_ld_q;
  logic                comp_en_q;
  logic                upd_en_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [IDX_W-1:0]    sel_idx_q;
  logic [ITER_W-1:0]   iter_cnt_q;
  logic [ITER_W-1:0]   iter_cnt_d;

  logic                start_edge_s;
  logic                at_limit_s;
  logic                is_single_s;
  logic                is_zero_s;
  logic [IDX_W-1:0]    lowest_idx_s;

  maxnet_onehot_check #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_onehot (
    .nz_i         (nz),
    .is_single_o  (is_single_s),
    .is_zero_o    (is_zero_s),
    .lowest_idx_o (lowest_idx_s)
  );

  assign start_edge_s = start && !start_q;
  assign at_limit_s   = (iter_cnt_q == ITER_W'(MAX_ITER));
  assign iter_cnt_d   = at_limit_s ? iter_cnt_q : iter_cnt_q + ITER_W'(1);

  // Control FSM; every output flop is loaded with the value of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      init_ld_q  <= 1'b0;
      comp_en_q  <= 1'b0;
      upd_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sel_idx_q  <= {IDX_W{1'b0}};
      iter_cnt_q <= {ITER_W{1'b0}};
    end else begin
      start_q   <= start;
      init_ld_q <= 1'b0;
      comp_en_q <= 1'b0;
      upd_en_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge_s) begin
            state_q    <= ST_LOAD;
            init_ld_q  <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            iter_cnt_q <= {ITER_W{1'b0}};
          end
        end
        ST_LOAD: begin
          state_q   <= ST_COMPUTE;
          comp_en_q <= 1'b1;
        end
        ST_COMPUTE: begin
          state_q  <= ST_UPDATE;
          upd_en_q <= 1'b1;
        end
        ST_UPDATE: begin
          state_q    <= ST_CHECK;
          iter_cnt_q <= iter_cnt_d;
        end
        ST_CHECK: begin
          // A lone survivor wins over the degenerate exits.
          if (is_single_s) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            sel_idx_q <= lowest_idx_s;
          end else if (is_zero_s) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            sel_idx_q <= {IDX_W{1'b0}};
          end else if (at_limit_s) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            sel_idx_q <= lowest_idx_s;
          end else begin
            state_q   <= ST_COMPUTE;
            comp_en_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          sel_idx_q  <= {IDX_W{1'b0}};
          iter_cnt_q <= {ITER_W{1'b0}};
        end
      endcase
    end
  end

  assign init_ld  = init_ld_q;
  assign comp_en  = comp_en_q;
  assign upd_en   = upd_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign sel_idx  = sel_idx_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller: directed table of runs, random
// runs against a timeline/result model, reset abort and start handling.
module tb_maxnet_controller;

  localparam int N    = 4;
  localparam int MAXI = 64;
  localparam int IW   = 7;
  localparam int XW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  nz;
  logic          init_ld, comp_en, upd_en, busy, done, err;
  logic [XW-1:0] sel_idx;
  logic [IW-1:0] iter_cnt;

  maxnet_controller #(.N(N), .MAX_ITER(MAXI), .ITER_W(IW), .IDX_W(XW)) dut (
    .clk(clk), .rst(rst), .start(start), .nz(nz),
    .init_ld(init_ld), .comp_en(comp_en), .upd_en(upd_en),
    .sel_idx(sel_idx), .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] cur_seq[$];
  logic [XW-1:0] prev_sel;
  logic          prev_err;
  logic          prev_done;
  int            prev_iter;

  typedef struct {
    logic [15:0] s;      // element j in bits [4j+3:4j]
    int          len;
    logic [1:0]  sel;
    logic        er;
    int          iters;
    bit          glitch;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {init_ld, comp_en, upd_en, busy, done, err, sel_idx, iter_cnt};
  endfunction

  function automatic logic [13:0] mk(input logic il, input logic ce, input logic ue,
                                     input logic bs, input logic dn, input logic er,
                                     input logic [1:0] s, input int it);
    logic [6:0] itv;
    itv = it[6:0];
    return {il, ce, ue, bs, dn, er, s, itv};
  endfunction

  function automatic logic [3:0] seq_at(input int i);
    if (i >= cur_seq.size()) return cur_seq[cur_seq.size() - 1];
    return cur_seq[i];
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int b = 0; b < N; b++) if (v[b]) return b;
    return 0;
  endfunction

  // Result rules: one survivor wins, all-zero or the round limit are errors.
  task automatic model_result(output int k, output logic [1:0] s, output logic er);
    logic [3:0] v;
    k = MAXI; s = 2'd0; er = 1'b1;
    for (int i = 0; i < MAXI; i++) begin
      v = seq_at(i);
      if ($countones(v) == 1) begin k = i + 1; s = 2'(lowest(v)); er = 1'b0; break; end
      else if (v == 4'd0) begin k = i + 1; s = 2'd0; er = 1'b1; break; end
      else if (i + 1 == MAXI) begin k = MAXI; s = 2'(lowest(v)); er = 1'b1; break; end
    end
  endtask

  // One run: start low for a cycle, rise, then check every cycle until DONE has held.
  task automatic run_case(input bit glitch, output int k_o, output logic [1:0] s_o, output logic er_o);
    int k, last, ncomp, nupd, it;
    logic [1:0] s;
    logic er, il, ce, ue, bs, dn;
    model_result(k, s, er);
    last = 3 * k + 2;
    @(negedge clk); start = 1'b0;
    check("pre_low", 32'(outs()), 32'(mk(0, 0, 0, 0, prev_done, prev_err, prev_sel, prev_iter)));
    @(negedge clk); start = 1'b1;
    check("pre_edge", 32'(outs()), 32'(mk(0, 0, 0, 0, prev_done, prev_err, prev_sel, prev_iter)));
    ncomp = 0; nupd = 0;
    for (int t = 1; t <= last + 2; t++) begin
      @(negedge clk);
      if (glitch && t == 2) start = 1'b0;
      if (glitch && t == 3) start = 1'b1;
      nz = (t >= 2) ? seq_at((t - 2) / 3) : seq_at(0);
      il = (t == 1);
      ce = (t >= 2) && (t <= 3 * k - 1) && ((t - 2) % 3 == 0);
      ue = (t >= 3) && (t <= 3 * k) && ((t - 3) % 3 == 0);
      bs = (t <= 3 * k + 1);
      dn = (t >= 3 * k + 2);
      it = (t < 4) ? 0 : (((t - 4) / 3 + 1) > k ? k : ((t - 4) / 3 + 1));
      if (comp_en) ncomp++;
      if (upd_en) nupd++;
      if (outs() !== mk(il, ce, ue, bs, dn, dn ? er : 1'b0, dn ? s : prev_sel, it)) begin
        $display("FAIL cycle t=%0d: got %0h expected %0h", t, outs(),
                 mk(il, ce, ue, bs, dn, dn ? er : 1'b0, dn ? s : prev_sel, it));
        errors++;
      end
      checks++;
    end
    check("comp_pulses", ncomp, k);
    check("upd_pulses", nupd, k);
    prev_sel = s; prev_err = er; prev_done = 1'b1; prev_iter = k;
    k_o = k; s_o = s; er_o = er;
  endtask

  task automatic load_vec(input logic [15:0] s, input int len);
    logic [15:0] w;
    w = s;
    cur_seq.delete();
    for (int j = 0; j < len; j++) cur_seq.push_back(w[4*j +: 4]);
  endtask

  initial begin
    int k;
    logic [1:0] s;
    logic er;
    int len;
    tbl[0] = '{16'h0004, 1, 2'd2, 1'b0, 1,  1'b0};
    tbl[1] = '{16'h23BF, 4, 2'd1, 1'b0, 4,  1'b0};
    tbl[2] = '{16'h0000, 1, 2'd0, 1'b1, 1,  1'b0};
    tbl[3] = '{16'h0006, 1, 2'd1, 1'b1, 64, 1'b0};
    tbl[4] = '{16'h0008, 1, 2'd3, 1'b0, 1,  1'b1};
    tbl[5] = '{16'h000D, 2, 2'd0, 1'b1, 2,  1'b0};
    prev_sel = 2'd0; prev_err = 1'b0; prev_done = 1'b0; prev_iter = 0;

    rst = 1'b0; start = 1'b0; nz = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(outs()), 32'd0);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      load_vec(tbl[v].s, tbl[v].len);
      run_case(tbl[v].glitch, k, s, er);
      check($sformatf("tbl%0d_sel", v), 32'(sel_idx), 32'(tbl[v].sel));
      check($sformatf("tbl%0d_err", v), 32'(err), 32'(tbl[v].er));
      check($sformatf("tbl%0d_iter", v), 32'(iter_cnt), 32'(tbl[v].iters));
      check($sformatf("tbl%0d_done", v), 32'(done), 32'd1);
    end

    // Reset asserted while the run sits in UPDATE.
    load_vec(16'h000F, 1);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_abort_upd", 32'(upd_en), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    check("abort_held", 32'(outs()), 32'd0);
    start = 1'b0; rst = 1'b1;
    prev_sel = 2'd0; prev_err = 1'b0; prev_done = 1'b0; prev_iter = 0;
    load_vec(16'h0002, 1);
    run_case(1'b0, k, s, er);
    check("after_abort_sel", 32'(sel_idx), 32'd1);

    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 5);
      cur_seq.delete();
      for (int j = 0; j < len; j++) cur_seq.push_back(4'($urandom_range(0, 15)));
      run_case(1'($urandom_range(0, 1)), k, s, er);
      check("rand_sel", 32'(sel_idx), 32'(s));
      check("rand_err", 32'(err), 32'(er));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
